// File: rtl/selftest_pkg.sv
// Shared definitions for the x25519 self-test sequencer: FSM states, counter
// width, the P25519 modulus for vector tables and small helpers.
package selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACK  = 3'd4,
    ST_DONE = 3'd5
  } st_e;

  localparam int CNT_W = 8;

  // 2^255 - 19
  localparam logic [254:0] P25519 = {255{1'b1}} - 255'd18;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/selftest_seq_wdog.sv
// Watchdog for the self-test sequencer: counts enabled cycles since the last
// clear and flags expiry once TMO cycles have been counted.
module selftest_wdog
  import selftest_pkg::*;
#(
  parameter int TMO = 1048576
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TMO - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT);
  // Holds at the limit so expiry stays asserted until the next clear.
  assign o_expire   = i_en && w_at_limit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/selftest_seq.sv
// Self-test sequencer: walks a DEPTH-entry vector table through a req/res DUT
// and tallies pass/fail. Define SELFTEST_TIMEOUT_EN to enable the watchdog.
module selftest_seq
  import selftest_pkg::*;
#(
  parameter int W     = 255,
  parameter int DEPTH = 4,
  parameter int IW    = idx_w(DEPTH),
  parameter int TMO   = 1048576
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             loop_en,
  output logic [IW-1:0]    vec_idx,
  input  logic [W-1:0]     vec_a,
  input  logic [W-1:0]     vec_b,
  input  logic [W-1:0]     vec_exp,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  output logic             dut_req_valid,
  input  logic             dut_req_ready,
  input  logic             dut_req_busy,
  input  logic             dut_res_valid,
  output logic             dut_res_ready,
  input  logic [W-1:0]     dut_res,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [IW-1:0]    first_fail_idx,
  output logic             timeout,
  output logic             busy,
  output logic             done
);

  st_e              r_state;
  logic [IW-1:0]    r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_exp;
  logic             r_req_valid;
  logic             r_res_ready;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [IW-1:0]    r_ffi;
  logic             r_timeout;
  logic             w_expire;
  logic             w_unused;

  assign w_unused = dut_req_busy;

`ifdef SELFTEST_TIMEOUT_EN
  selftest_wdog #(.TMO(TMO)) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (r_state == ST_LOAD),
    .i_en     ((r_state == ST_REQ) || (r_state == ST_WAIT)),
    .o_expire (w_expire)
  );
`else
  localparam int unused_tmo = TMO;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_exp       <= '0;
      r_req_valid <= 1'b0;
      r_res_ready <= 1'b0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_ffi       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_pass    <= '0;
            r_fail    <= '0;
            r_ffi     <= '0;
            r_timeout <= 1'b0;
            r_idx     <= '0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_a         <= vec_a;
          r_b         <= vec_b;
          r_exp       <= vec_exp;
          r_req_valid <= 1'b1;
          r_state     <= ST_REQ;
        end
        ST_REQ: begin
          if (r_req_valid && dut_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end else if (w_expire) begin
            r_timeout   <= 1'b1;
            r_fail      <= sat_inc(r_fail);
            if (r_fail == '0) r_ffi <= r_idx;
            r_req_valid <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle is still scored.
          if (dut_res_valid) begin
            if (dut_res == r_exp) begin
              r_pass <= sat_inc(r_pass);
            end else begin
              r_fail <= sat_inc(r_fail);
              if (r_fail == '0) r_ffi <= r_idx;
            end
            r_res_ready <= 1'b1;
            r_state     <= ST_ACK;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_fail    <= sat_inc(r_fail);
            if (r_fail == '0) r_ffi <= r_idx;
            r_state   <= ST_DONE;
          end
        end
        ST_ACK: begin
          if (!dut_res_valid) begin
            r_res_ready <= 1'b0;
            if (r_idx != IW'(DEPTH - 1)) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOAD;
            end else if (loop_en) begin
              r_idx   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vec_idx        = r_idx;
  assign dut_a          = r_a;
  assign dut_b          = r_b;
  assign dut_req_valid  = r_req_valid;
  assign dut_res_ready  = r_res_ready;
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign first_fail_idx = r_ffi;
  assign timeout        = r_timeout;
  assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done           = (r_state == ST_DONE);

endmodule

// File: tb/tb_selftest_seq.sv
// Directed bench for selftest_seq with a mock (a+b) mod 251 DUT of 3-cycle
// latency; timeout scenario runs only when SELFTEST_TIMEOUT_EN is defined.
module tb_selftest_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] vec_idx;
  logic [7:0] vec_a, vec_b, vec_exp;
  logic [7:0] dut_a, dut_b, dut_res;
  logic       dut_req_valid, dut_req_ready, dut_req_busy;
  logic       dut_res_valid, dut_res_ready;
  logic [7:0] pass_cnt, fail_cnt;
  logic [1:0] first_fail_idx;
  logic       timeout, busy, done;

  logic [7:0] tb_a [4];
  logic [7:0] tb_b [4];
  logic [7:0] tb_e [4];

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign vec_a   = tb_a[vec_idx];
  assign vec_b   = tb_b[vec_idx];
  assign vec_exp = tb_e[vec_idx];

  selftest_seq #(.W(8), .DEPTH(4), .TMO(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .loop_en        (loop_en),
    .vec_idx        (vec_idx),
    .vec_a          (vec_a),
    .vec_b          (vec_b),
    .vec_exp        (vec_exp),
    .dut_a          (dut_a),
    .dut_b          (dut_b),
    .dut_req_valid  (dut_req_valid),
    .dut_req_ready  (dut_req_ready),
    .dut_req_busy   (dut_req_busy),
    .dut_res_valid  (dut_res_valid),
    .dut_res_ready  (dut_res_ready),
    .dut_res        (dut_res),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .timeout        (timeout),
    .busy           (busy),
    .done           (done)
  );

  // Mock arithmetic DUT
  int         stall_cycles = 0;
  bit         never_respond = 1'b0;
  int         m_state = 0;
  int         m_stall = 0;
  int         m_lat = 0;
  int         m_accepts = 0;
  logic [7:0] m_z = '0;
  logic       m_res_valid = 1'b0;

  assign dut_req_ready = (m_state == 0) && (m_stall >= stall_cycles);
  assign dut_req_busy  = (m_state != 0);
  assign dut_res_valid = m_res_valid;
  assign dut_res       = m_z;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state     <= 0;
      m_stall     <= 0;
      m_lat       <= 0;
      m_z         <= '0;
      m_res_valid <= 1'b0;
    end else begin
      case (m_state)
        0: if (dut_req_valid) begin
          if (dut_req_ready) begin
            m_z       <= 8'((int'(dut_a) + int'(dut_b)) % 251);
            m_accepts <= m_accepts + 1;
            m_stall   <= 0;
            m_lat     <= 0;
            m_state   <= 1;
          end else begin
            m_stall <= m_stall + 1;
          end
        end
        1: if (!never_respond) begin
          if (m_lat == 2) begin
            m_res_valid <= 1'b1;
            m_state     <= 2;
          end else begin
            m_lat <= m_lat + 1;
          end
        end
        default: if (dut_res_ready) begin
          m_res_valid <= 1'b0;
          m_state     <= 0;
        end
      endcase
    end
  end

  // dut_res_ready must only rise while a result is being presented
  logic prev_rr = 1'b0;
  int   rr_viol = 0;
  always @(posedge clk) begin
    if (dut_res_ready && !prev_rr && !dut_res_valid) rr_viol <= rr_viol + 1;
    prev_rr <= dut_res_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reqv"},  32'(dut_req_valid), 0);
    check({tag, "_resr"},  32'(dut_res_ready), 0);
    check({tag, "_a"},     32'(dut_a), 0);
    check({tag, "_b"},     32'(dut_b), 0);
    check({tag, "_idx"},   32'(vec_idx), 0);
    check({tag, "_pass"},  32'(pass_cnt), 0);
    check({tag, "_fail"},  32'(fail_cnt), 0);
    check({tag, "_ffi"},   32'(first_fail_idx), 0);
    check({tag, "_tmo"},   32'(timeout), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check("wait_done", 32'(done), 1);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n = 0;
    while (m_accepts < target && n < budget) begin @(negedge clk); n++; end
    check("wait_accepts", 32'(m_accepts >= target), 1);
  endtask

  task automatic wait_pass(input int target, input int budget);
    int n = 0;
    while (int'(pass_cnt) < target && n < budget) begin @(negedge clk); n++; end
    check("wait_pass", 32'(pass_cnt), 32'(target));
  endtask

  task automatic load_good();
    tb_a[0] = 8'd10;  tb_b[0] = 8'd20;  tb_e[0] = 8'd30;
    tb_a[1] = 8'd200; tb_b[1] = 8'd100; tb_e[1] = 8'd49;
    tb_a[2] = 8'd250; tb_b[2] = 8'd5;   tb_e[2] = 8'd4;
    tb_a[3] = 8'd100; tb_b[3] = 8'd151; tb_e[3] = 8'd0;
  endtask

  initial begin
    int base;
    load_good();

    #1 rstn = 1'b0;
    #1 check_all_zero("rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // all vectors correct; a stray start mid-run must not restart the table
    base = m_accepts;
    pulse_start();
    wait_pass(2, 200);
    pulse_start();
    wait_done(400);
    check("good_pass",    32'(pass_cnt), 4);
    check("good_fail",    32'(fail_cnt), 0);
    check("good_tmo",     32'(timeout), 0);
    check("good_busy",    32'(busy), 0);
    check("good_accepts", 32'(m_accepts - base), 4);

    // expected value of vector 2 off by one
    tb_e[2] = 8'd5;
    pulse_start();
    wait_done(400);
    check("bad2_pass", 32'(pass_cnt), 3);
    check("bad2_fail", 32'(fail_cnt), 1);
    check("bad2_ffi",  32'(first_fail_idx), 2);
    tb_e[2] = 8'd4;

    // request stalled 5 cycles per vector
    stall_cycles = 5;
    base = m_accepts;
    pulse_start();
    check("lat_k1_reqv", 32'(dut_req_valid), 0);
    @(negedge clk);
    check("lat_k2_reqv", 32'(dut_req_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {14'd0, dut_req_valid, dut_req_ready, dut_a, dut_b},
            {14'd0, 1'b1, 1'b0, 8'd10, 8'd20});
      @(negedge clk);
    end
    wait_done(600);
    check("stall_accepts", 32'(m_accepts - base), 4);
    check("stall_pass",    32'(pass_cnt), 4);
    check("rr_order",      32'(rr_viol), 0);
    stall_cycles = 0;

    // every vector wrong, looping: fail_cnt saturates, drop loop_en in pass 69
    tb_e[0] = 8'd31; tb_e[1] = 8'd50; tb_e[2] = 8'd5; tb_e[3] = 8'd1;
    loop_en = 1'b1;
    base = m_accepts;
    pulse_start();
    wait_accepts(base + 273, 5000);
    check("loop_sat_fail", 32'(fail_cnt), 255);
    check("loop_pass",     32'(pass_cnt), 0);
    check("loop_busy",     32'(busy), 1);
    loop_en = 1'b0;
    wait_done(200);
    check("loop_accepts", 32'(m_accepts - base), 276);
    check("loop_fail",    32'(fail_cnt), 255);
    check("loop_ffi",     32'(first_fail_idx), 0);
    check("loop_idx",     32'(vec_idx), 3);
    load_good();

    // asynchronous reset while waiting on the second result
    base = m_accepts;
    pulse_start();
    wait_accepts(base + 2, 200);
    check("pre_rst_pass", 32'(pass_cnt), 1);
    check("pre_rst_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    pulse_start();
    wait_done(400);
    check("post_rst_pass", 32'(pass_cnt), 4);
    check("post_rst_fail", 32'(fail_cnt), 0);

`ifdef SELFTEST_TIMEOUT_EN
    never_respond = 1'b1;
    pulse_start();
    wait_done(200);
    check("tmo_flag", 32'(timeout), 1);
    check("tmo_fail", 32'(fail_cnt), 1);
    check("tmo_ffi",  32'(first_fail_idx), 0);
    check("tmo_reqv", 32'(dut_req_valid), 0);
    never_respond = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
